// File: rtl/qam_demod_core.sv
// qam_demod_core: real passband sample mixed with an internal NCO, integrated over SPS samples,
// then sliced per axis to Gray bits. Last sample of a symbol to dout_valid is a fixed 3 cycles.
module qam_demod_core #(
    parameter int               IN_W      = 10,
    parameter int               LUT_W     = 8,
    parameter int               NCO_W     = 16,
    parameter logic [NCO_W-1:0] PHASE_INC = 16'h2000,
    parameter int               SPS       = 8,
    localparam int              ACC_W     = IN_W + LUT_W + $clog2(SPS)
) (
    input  logic                    axi_clk,
    input  logic                    axi_rstn,
    input  logic                    qam_valid,
    input  logic signed [IN_W-1:0]  qam_in,
    input  logic                    sync,
    input  logic [1:0]              mode,
    input  logic [ACC_W-1:0]        thr,
    output logic                    dout_valid,
    output logic [5:0]              dout,
    output logic signed [ACC_W-1:0] sym_i,
    output logic signed [ACC_W-1:0] sym_q
);

    localparam int PROD_W = IN_W + LUT_W;
    localparam int CNT_W  = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int SW     = ACC_W + 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);

    // Quarter-wave of round(127*sin(2*pi*k/256)), k = 0..64; amplitude matches LUT_W = 8.
    localparam logic [6:0] QSIN [65] = '{
        7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,  7'd25,  7'd28,
        7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,  7'd49,  7'd51,  7'd54,  7'd57,
        7'd60,  7'd63,  7'd65,  7'd68,  7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,
        7'd85,  7'd88,  7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
        7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116, 7'd117, 7'd118,
        7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124, 7'd125, 7'd125, 7'd126, 7'd126,
        7'd126, 7'd127, 7'd127, 7'd127, 7'd127
    };

    function automatic logic signed [LUT_W-1:0] lut_sin(input logic [7:0] k);
        logic [6:0]              m;
        logic signed [LUT_W-1:0] s;
        m = k[6] ? (7'd64 - {1'b0, k[5:0]}) : {1'b0, k[5:0]};
        s = LUT_W'(signed'({1'b0, QSIN[m]}));
        return k[7] ? -s : s;
    endfunction

    // Number of decision boundaries k*2*thr (|k| <= lim) at or below v.
    function automatic logic [2:0] slice_idx(input logic signed [ACC_W-1:0] v,
                                             input logic [ACC_W-1:0] t, input int lim);
        logic signed [SW-1:0] v_x;
        logic signed [SW-1:0] t2_x;
        logic signed [SW-1:0] bnd;
        logic [2:0]           idx;
        v_x  = SW'(v);
        t2_x = SW'({t, 1'b0});
        idx  = 3'd0;
        for (int k = -3; k <= 3; k++) begin
            bnd = SW'(k) * t2_x;
            if ((k >= -lim) && (k <= lim) && (v_x >= bnd)) idx = idx + 3'd1;
        end
        return idx;
    endfunction

    function automatic logic [2:0] gray3(input logic [2:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic int mode_lim(input logic [1:0] md);
        case (md)
            2'd1:    return 1;
            2'd2:    return 3;
            default: return 0;
        endcase
    endfunction

    logic [NCO_W-1:0]         r_phase;
    logic [CNT_W-1:0]         r_cnt;
    logic [1:0]               r_mode_sym;
    logic                     r_v1, r_first1, r_last1;
    logic [1:0]               r_mode1, r_mode2;
    logic signed [PROD_W-1:0] r_prod_i, r_prod_q;
    logic                     r_dump2;
    logic signed [ACC_W-1:0]  r_acc_i, r_acc_q;
    logic                     r_dout_valid;
    logic [5:0]               r_dout;
    logic signed [ACC_W-1:0]  r_sym_i, r_sym_q;

    logic [NCO_W-1:0]         w_phase_use;
    logic [7:0]               w_lut_k;
    logic signed [LUT_W-1:0]  w_cos, w_sin;
    logic signed [PROD_W-1:0] w_mul_i, w_mul_q;
    logic signed [ACC_W-1:0]  w_ext_i, w_ext_q;
    logic                     w_first, w_last;
    logic [1:0]               w_mode_sym;
    int                       w_lim;
    logic [2:0]               w_gi, w_gq;
    logic [5:0]               w_dout;

    assign w_first     = (r_cnt == '0) | sync;
    assign w_last      = (r_cnt == CNT_LAST) & ~sync;
    assign w_mode_sym  = w_first ? mode : r_mode_sym;
    assign w_phase_use = sync ? '0 : r_phase;
    assign w_lut_k     = w_phase_use[NCO_W-1 -: 8];
    assign w_cos       = lut_sin(w_lut_k + 8'd64);
    assign w_sin       = lut_sin(w_lut_k);
    assign w_mul_i     = qam_in * w_cos;
    assign w_mul_q     = -(qam_in * w_sin);
    assign w_ext_i     = {{(ACC_W-PROD_W){r_prod_i[PROD_W-1]}}, r_prod_i};
    assign w_ext_q     = {{(ACC_W-PROD_W){r_prod_q[PROD_W-1]}}, r_prod_q};

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            r_phase    <= '0;
            r_cnt      <= '0;
            r_mode_sym <= '0;
        end else if (qam_valid) begin
            r_phase    <= w_phase_use + PHASE_INC;
            r_cnt      <= sync ? CNT_W'(1) : ((r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1);
            r_mode_sym <= w_mode_sym;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            r_v1     <= 1'b0;
            r_first1 <= 1'b0;
            r_last1  <= 1'b0;
            r_mode1  <= '0;
            r_prod_i <= '0;
            r_prod_q <= '0;
        end else begin
            r_v1 <= qam_valid;
            if (qam_valid) begin
                r_first1 <= w_first;
                r_last1  <= w_last;
                r_mode1  <= w_mode_sym;
                r_prod_i <= w_mul_i;
                r_prod_q <= w_mul_q;
            end
        end
    end

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            r_dump2 <= 1'b0;
            r_mode2 <= '0;
            r_acc_i <= '0;
            r_acc_q <= '0;
        end else begin
            r_dump2 <= r_v1 & r_last1;
            if (r_v1) begin
                r_mode2 <= r_mode1;
                r_acc_i <= r_first1 ? w_ext_i : r_acc_i + w_ext_i;
                r_acc_q <= r_first1 ? w_ext_q : r_acc_q + w_ext_q;
            end
        end
    end

    always_comb begin
        w_lim  = mode_lim(r_mode2);
        w_gi   = gray3(slice_idx(r_acc_i, thr, w_lim));
        w_gq   = gray3(slice_idx(r_acc_q, thr, w_lim));
        w_dout = {4'b0000, w_gi[0], w_gq[0]};
        case (r_mode2)
            2'd1:    w_dout = {2'b00, w_gi[1:0], w_gq[1:0]};
            2'd2:    w_dout = {w_gi, w_gq};
            default: w_dout = {4'b0000, w_gi[0], w_gq[0]};
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            r_dout_valid <= 1'b0;
            r_dout       <= '0;
            r_sym_i      <= '0;
            r_sym_q      <= '0;
        end else begin
            r_dout_valid <= r_dump2;
            if (r_dump2) begin
                r_dout  <= w_dout;
                r_sym_i <= r_acc_i;
                r_sym_q <= r_acc_q;
            end
        end
    end

    assign dout_valid = r_dout_valid;
    assign dout       = r_dout;
    assign sym_i      = r_sym_i;
    assign sym_q      = r_sym_q;

endmodule

// File: tb/tb_qam_demod_core.sv
// Directed bench for qam_demod_core: fs/8 carrier tone symbols with hand-computed dumps
// (|I| = |Q| = 50780) sliced under each mode, gaps, mid-symbol sync and mid-run reset.
module tb_qam_demod_core;
    localparam int ACC_W = 21;

    logic                    axi_clk   = 1'b0;
    logic                    axi_rstn  = 1'b0;
    logic                    qam_valid = 1'b0;
    logic signed [9:0]       qam_in    = '0;
    logic                    sync      = 1'b0;
    logic [1:0]              mode      = 2'd0;
    logic [ACC_W-1:0]        thr       = '0;
    logic                    dout_valid;
    logic [5:0]              dout;
    logic signed [ACC_W-1:0] sym_i, sym_q;

    int n_assert  = 0;
    int n_fail    = 0;
    int pulse_cnt = 0;
    int pc0       = 0;
    int pat [8]   = '{100, 0, -100, -141, -100, 0, 100, 141};

    qam_demod_core dut (
        .axi_clk    (axi_clk),
        .axi_rstn   (axi_rstn),
        .qam_valid  (qam_valid),
        .qam_in     (qam_in),
        .sync       (sync),
        .mode       (mode),
        .thr        (thr),
        .dout_valid (dout_valid),
        .dout       (dout),
        .sym_i      (sym_i),
        .sym_q      (sym_q)
    );

    always #5 axi_clk = ~axi_clk;

    always @(posedge axi_clk) if (dout_valid) pulse_cnt <= pulse_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        qam_valid = 1'b0;
        sync      = 1'b0;
        qam_in    = '0;
    endtask

    task automatic send_sym(input bit neg, input bit gaps, input bit use_sync,
                            input logic [1:0] mode_at4);
        for (int n = 0; n < 8; n++) begin
            @(negedge axi_clk);
            qam_valid = 1'b1;
            qam_in    = neg ? 10'(-pat[n]) : 10'(pat[n]);
            sync      = use_sync && (n == 0);
            if (n == 4) mode = mode_at4;
            if (gaps && n < 7) begin
                @(negedge axi_clk);
                idle();
            end
        end
    endtask

    // Last sample captured at edge E: dout_valid must be low after E+1, high after E+2 only.
    task automatic expect_dump(input string tag, input logic [5:0] exp_d,
                               input int exp_i, input int exp_q);
        @(negedge axi_clk);
        idle();
        @(negedge axi_clk);
        check({tag, "/early"}, dout_valid, 0);
        @(negedge axi_clk);
        check({tag, "/valid"}, dout_valid, 1);
        check({tag, "/dout"}, dout, exp_d);
        check({tag, "/sym_i"}, sym_i, exp_i);
        check({tag, "/sym_q"}, sym_q, exp_q);
        @(negedge axi_clk);
        check({tag, "/pulse_end"}, dout_valid, 0);
        check({tag, "/hold_i"}, sym_i, exp_i);
        check({tag, "/pulses"}, pulse_cnt, pc0 + 1);
    endtask

    initial begin
        #12;
        check("rst/valid", dout_valid, 0);
        check("rst/dout", dout, 0);
        check("rst/sym_i", sym_i, 0);
        check("rst/sym_q", sym_q, 0);
        @(negedge axi_clk);
        axi_rstn = 1'b1;

        mode = 2'd0; thr = '0; pc0 = pulse_cnt;
        send_sym(0, 0, 1, 2'd0);
        expect_dump("qpsk", 6'b000011, 50780, 50780);

        mode = 2'd1; thr = 21'd25390; pc0 = pulse_cnt;
        send_sym(0, 0, 1, 2'd1);
        expect_dump("qam16_bnd", 6'b001010, 50780, 50780);

        pc0 = pulse_cnt;
        send_sym(1, 0, 1, 2'd1);
        expect_dump("qam16_neg", 6'b000101, -50780, -50780);

        mode = 2'd0; pc0 = pulse_cnt;
        send_sym(0, 1, 1, 2'd0);
        expect_dump("qpsk_gaps", 6'b000011, 50780, 50780);

        mode = 2'd2; thr = 21'd10000; pc0 = pulse_cnt;
        send_sym(1, 0, 1, 2'd2);
        expect_dump("qam64_neg", 6'b001001, -50780, -50780);

        // Four samples of a negated symbol, then sync restarts on the fifth.
        mode = 2'd0; pc0 = pulse_cnt;
        for (int n = 0; n < 4; n++) begin
            @(negedge axi_clk);
            qam_valid = 1'b1;
            qam_in    = 10'(-pat[n]);
            sync      = (n == 0);
        end
        send_sym(0, 0, 1, 2'd0);
        expect_dump("resync", 6'b000011, 50780, 50780);

        mode = 2'd0; thr = 21'd10000; pc0 = pulse_cnt;
        send_sym(0, 0, 1, 2'd2);
        expect_dump("mode_old", 6'b000011, 50780, 50780);
        pc0 = pulse_cnt;
        send_sym(0, 0, 1, 2'd2);
        expect_dump("mode_new", 6'b101101, 50780, 50780);

        thr = 21'd25390; pc0 = pulse_cnt;
        send_sym(0, 0, 1, 2'd2);
        expect_dump("qam64_bnd", 6'b111111, 50780, 50780);

        mode = 2'd0;
        for (int n = 0; n < 5; n++) begin
            @(negedge axi_clk);
            qam_valid = 1'b1;
            qam_in    = 10'(-pat[n]);
            sync      = (n == 0);
        end
        @(negedge axi_clk);
        idle();
        axi_rstn = 1'b0;
        #1;
        check("rst_mid/valid", dout_valid, 0);
        check("rst_mid/dout", dout, 0);
        check("rst_mid/sym_i", sym_i, 0);
        check("rst_mid/sym_q", sym_q, 0);
        @(negedge axi_clk);
        axi_rstn = 1'b1;
        pc0 = pulse_cnt;
        send_sym(0, 1, 0, 2'd0);
        expect_dump("post_rst", 6'b000011, 50780, 50780);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
